// File: rtl/rtc_pkg.sv
// rtc_pkg: shared FSM state encoding, owner encoding (matches sel_bus) and default watchdog limit
package rtc_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT_L = 2'd1, GRANT_E = 2'd2, RELEASE = 2'd3} state_t;
  typedef enum logic {LECT = 1'b0, ESCR = 1'b1} owner_t;
  localparam int TIMEOUT_CYCLES_DEF = 1024;
endpackage

// File: rtl/rtc_watchdog_cnt.sv
// rtc_watchdog_cnt: saturating cycle counter; clk/reset, clr zeroes, en counts, tc flags count == MAX-1
module rtc_watchdog_cnt #(
  parameter int MAX = 1024,
  parameter int W = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (en && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign tc = cnt_q == W'(MAX - 1);
endmodule

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: round-robin RTC bus owner; in clk/reset/req_*/fin_*, out gnt_*/sel_bus/bus_ocupado/timeout_err
module rtc_bus_arbiter
  import rtc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int TO_W = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic req_lect,
  input  logic req_escr,
  input  logic fin_lect,
  input  logic fin_escr,
  output logic gnt_lect,
  output logic gnt_escr,
  output logic sel_bus,
  output logic bus_ocupado,
  output logic timeout_err
);
  state_t state_q, state_d;
  owner_t last_q, last_d;
  logic sel_q, sel_d, timeout_q, timeout_d, tc;
  rtc_watchdog_cnt #(.MAX(TIMEOUT_CYCLES), .W(TO_W)) u_wd (
    .clk(clk),
    .reset(reset),
    .clr(state_q != GRANT_L && state_q != GRANT_E),
    .en(state_q == GRANT_L || state_q == GRANT_E),
    .tc(tc)
  );
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    sel_d = sel_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE:
        if (req_lect && (!req_escr || last_q == ESCR)) begin
          state_d = GRANT_L;
          sel_d = LECT;
        end else if (req_escr) begin
          state_d = GRANT_E;
          sel_d = ESCR;
        end
      GRANT_L:
        if (fin_lect || !req_lect || tc) begin
          state_d = RELEASE;
          last_d = LECT;
          timeout_d = tc && !fin_lect;
        end
      GRANT_E:
        if (fin_escr || !req_escr || tc) begin
          state_d = RELEASE;
          last_d = ESCR;
          timeout_d = tc && !fin_escr;
        end
      RELEASE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    state_q <= reset ? IDLE : state_d;
    last_q <= reset ? LECT : last_d;
    sel_q <= reset ? 1'b0 : sel_d;
    timeout_q <= reset ? 1'b0 : timeout_d;
  end
  assign gnt_lect = state_q == GRANT_L;
  assign gnt_escr = state_q == GRANT_E;
  assign sel_bus = sel_q;
  assign bus_ocupado = state_q != IDLE;
  assign timeout_err = timeout_q;
endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb_rtc_bus_arbiter: directed and random stimulus checked cycle by cycle against a bus-ownership model
module tb_rtc_bus_arbiter;
  localparam int T = 16;
  logic clk = 1'b0, reset = 1'b1, req_lect = 1'b0, req_escr = 1'b0, fin_lect = 1'b0, fin_escr = 1'b0;
  logic gnt_lect, gnt_escr, sel_bus, bus_ocupado, timeout_err;
  int errors = 0, checks = 0;
  int owner = -1, last = 0, held = 0;
  bit gap = 1'b0, sel = 1'b0, to = 1'b0;
  always #5 clk = ~clk;
  rtc_bus_arbiter #(.TIMEOUT_CYCLES(T), .TO_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .req_lect(req_lect),
    .req_escr(req_escr),
    .fin_lect(fin_lect),
    .fin_escr(fin_escr),
    .gnt_lect(gnt_lect),
    .gnt_escr(gnt_escr),
    .sel_bus(sel_bus),
    .bus_ocupado(bus_ocupado),
    .timeout_err(timeout_err)
  );
  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask
  // owner: -1 none, 0 reader, 1 writer; gap marks the single dead cycle after a release
  task automatic model();
    bit f, r;
    to = 1'b0;
    if (reset) begin
      owner = -1; gap = 1'b0; last = 0; sel = 1'b0; held = 0;
    end else if (owner >= 0) begin
      f = (owner == 1) ? fin_escr : fin_lect;
      r = (owner == 1) ? req_escr : req_lect;
      held++;
      if (f || !r || held == T) begin
        to = (held == T) && !f;
        last = owner; owner = -1; gap = 1'b1;
      end
    end else if (gap) begin
      gap = 1'b0;
    end else begin
      owner = (req_lect && req_escr) ? 1 - last : req_lect ? 0 : req_escr ? 1 : -1;
      if (owner >= 0) begin
        sel = (owner == 1);
        held = 0;
      end
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model();
      #1;
      chk("gnt_lect", gnt_lect, owner == 0);
      chk("gnt_escr", gnt_escr, owner == 1);
      chk("sel_bus", sel_bus, sel);
      chk("bus_ocupado", bus_ocupado, owner >= 0 || gap);
      chk("timeout_err", timeout_err, to);
      chk("gnt_overlap", gnt_lect & gnt_escr, 1'b0);
    end
  endtask
  initial begin
    cyc(2);
    reset = 1'b0;
    cyc(3);
    req_lect = 1'b1;
    cyc(15);
    fin_lect = 1'b1;
    cyc(1);
    fin_lect = 1'b0; req_lect = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0; req_lect = 1'b1; req_escr = 1'b1;
    cyc(5);
    fin_escr = 1'b1;
    cyc(1);
    fin_escr = 1'b0; req_escr = 1'b0;
    cyc(6);
    fin_lect = 1'b1;
    cyc(1);
    fin_lect = 1'b0; req_lect = 1'b0;
    cyc(2);
    req_escr = 1'b1;
    cyc(22);
    req_escr = 1'b0;
    cyc(3);
    req_lect = 1'b1;
    cyc(3);
    fin_escr = 1'b1;
    cyc(1);
    fin_escr = 1'b0;
    cyc(4);
    fin_lect = 1'b1;
    cyc(1);
    fin_lect = 1'b0; req_lect = 1'b0;
    cyc(2);
    req_escr = 1'b1;
    cyc(4);
    req_lect = 1'b1;
    cyc(2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0; req_escr = 1'b0;
    cyc(4);
    req_lect = 1'b0;
    cyc(3);
    req_lect = 1'b1;
    cyc(3);
    req_lect = 1'b0;
    cyc(3);
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) req_lect = ~req_lect;
      if ($urandom_range(0, 7) == 0) req_escr = ~req_escr;
      fin_lect = $urandom_range(0, 9) == 0;
      fin_escr = $urandom_range(0, 9) == 0;
      reset = $urandom_range(0, 299) == 0;
      cyc(1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
